// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-side responder: MMIO register offsets,
// STATUS bit positions and the size of the MMIO window.
package dmem_mmio_pkg;

  localparam int unsigned WINDOW_BYTES = 32;

  localparam logic [4:0] OFF_TXDATA   = 5'h00;
  localparam logic [4:0] OFF_STATUS   = 5'h04;
  localparam logic [4:0] OFF_CYCLE_LO = 5'h08;
  localparam logic [4:0] OFF_CYCLE_HI = 5'h0C;
  localparam logic [4:0] OFF_EXIT     = 5'h10;

  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_OVF   = 2;

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte FIFO feeding the TX consumer; a push into a full FIFO is still
// accepted when the head is popped on the same edge.
module dmem_mmio_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic                     accept,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign full   = (count == (PW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  assign accept = push & (~full | do_pop);
  assign dout   = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({accept, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; stale entries are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory slave for the RV32E core: word RAM with combinational reads
// plus an MMIO window holding TX FIFO, cycle counter, exit and error state.
module dmem_mmio_responder
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter int          TX_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_we,
  input  logic        dmem_re,
  output logic [31:0] dmem_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic [4:0]    off;
  logic          in_ram;
  logic          in_mmio;
  logic          mmio_we;
  logic          mmio_re;
  logic          bad_access;
  logic [63:0]   cycle_cnt;
  logic [31:0]   hi_shadow;
  logic          overflow;
  logic [31:0]   status_word;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] tx_count;

  // Low address bits are ignored for the access itself; misalignment only flags err.
  assign ram_idx = dmem_addr[AW+1:2];
  assign off     = {dmem_addr[4:2], 2'b00};
  assign in_ram  = (dmem_addr[31:AW+2] == '0);
  assign in_mmio = (dmem_addr[31:5] == MMIO_BASE[31:5]);
  assign mmio_we = dmem_we & in_mmio;
  assign mmio_re = dmem_re & in_mmio;

  assign bad_access = (dmem_we | dmem_re) &
                      ((dmem_addr[1:0] != 2'b00) | (~in_ram & ~in_mmio));

  assign push     = mmio_we & (off == OFF_TXDATA);
  assign tx_valid = (tx_count != '0);
  assign pop      = tx_valid & tx_ready;

  dmem_mmio_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .din    (dmem_wdata[7:0]),
    .pop    (pop),
    .dout   (tx_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .accept (push_ok),
    .count  (tx_count)
  );

  always_comb begin
    status_word         = '0;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_OVF]   = overflow;
  end

  always_comb begin
    dmem_rdata = '0;
    if (dmem_re) begin
      if (in_ram) begin
        dmem_rdata = ram[ram_idx];
      end else if (in_mmio) begin
        case (off)
          OFF_STATUS:   dmem_rdata = status_word;
          OFF_CYCLE_LO: dmem_rdata = cycle_cnt[31:0];
          OFF_CYCLE_HI: dmem_rdata = hi_shadow;
          default:      dmem_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (dmem_we && in_ram) ram[ram_idx] <= dmem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      hi_shadow <= '0;
      overflow  <= 1'b0;
      halt      <= 1'b0;
      halt_code <= '0;
      err       <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      // Shadow takes the pre-increment upper half so LO/HI form one snapshot.
      if (mmio_re && off == OFF_CYCLE_LO) hi_shadow <= cycle_cnt[63:32];
      if (push && !push_ok)
        overflow <= 1'b1;
      else if (mmio_we && off == OFF_STATUS && dmem_wdata[ST_OVF])
        overflow <= 1'b0;
      if (mmio_we && off == OFF_EXIT && !halt) begin
        halt      <= 1'b1;
        halt_code <= dmem_wdata;
      end
      if (bad_access) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: table-driven RAM/MMIO vectors, a TX byte
// scoreboard, and hand-written sequences for overflow, counter, exit, err, reset.
module tb_dmem_mmio_responder;

  localparam logic [31:0] MB    = 32'h1000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic [31:0] dmem_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;
  logic [31:0] halt_code;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb [$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  dmem_mmio_responder #(.RAM_WORDS(1024), .TX_DEPTH(DEPTH), .MMIO_BASE(MB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_re    (dmem_re),
    .dmem_rdata (dmem_rdata),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .halt       (halt),
    .halt_code  (halt_code),
    .err        (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    @(negedge clk);
    dmem_addr  = a;
    dmem_wdata = d;
    dmem_we    = w;
    dmem_re    = r;
    #1;
  endtask

  task automatic idle();
    access(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    access(MB, {24'h0, b}, 1'b1, 1'b0);
    if (sb.size() < DEPTH) sb.push_back(b);
  endtask

  // Called with inputs idle; pops one scoreboard byte per cycle while valid.
  task automatic drain(input int limit);
    tx_ready = 1'b1;
    for (int i = 0; i < limit && sb.size() > 0; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      check("tx_valid_during_drain", tx_valid, 1);
      if (tx_valid) check("tx_data", tx_data, sb.pop_front());
    end
    check("drain_timeout_left", sb.size(), 0);
    @(negedge clk);
    #1;
    tx_ready = 1'b0;
    check("tx_valid_after_drain", tx_valid, 0);
    check("tx_data_after_drain", tx_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tx_ready = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; dmem_we = 1'b0; dmem_re = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_halt", halt, 0);
    check("rst_halt_code", halt_code, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // Counter reads 10 after ten edges out of reset.
    repeat (10) @(posedge clk);
    access(MB + 32'h08, 0, 1'b0, 1'b1);
    check("cycle_lo_at_10", dmem_rdata, 10);
    access(MB + 32'h0C, 0, 1'b0, 1'b1);
    check("cycle_hi_shadow", dmem_rdata, 0);

    vecs.push_back('{32'h40,        32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{32'h40,        32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{32'h40,        32'h1,         1'b1, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{32'h40,        32'h0,         1'b0, 1'b1, 32'h1});
    vecs.push_back('{32'h44,        32'h1234_5678, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{32'h44,        32'h0,         1'b0, 1'b1, 32'h1234_5678});
    vecs.push_back('{32'hFFC,       32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{32'hFFC,       32'h0,         1'b0, 1'b1, 32'hA5A5_A5A5});
    vecs.push_back('{32'h40,        32'h0,         1'b0, 1'b0, 32'h0});
    vecs.push_back('{MB,            32'h0,         1'b0, 1'b1, 32'h0});
    vecs.push_back('{MB + 32'h04,   32'h0,         1'b0, 1'b1, 32'h2});
    vecs.push_back('{MB + 32'h18,   32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0});
    vecs.push_back('{MB + 32'h14,   32'h0,         1'b0, 1'b1, 32'h0});
    vecs.push_back('{MB + 32'h08,   32'h1234,      1'b1, 1'b0, 32'h0});
    vecs.push_back('{MB + 32'h0C,   32'h0,         1'b0, 1'b1, 32'h0});
    foreach (vecs[i]) begin
      access(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re);
      check($sformatf("vec%0d_rdata", i), dmem_rdata, vecs[i].exp);
    end
    idle();
    check("err_clean_after_table", err, 0);

    // Three bytes held, then streamed out.
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    idle();
    check("tx_valid_held", tx_valid, 1);
    check("tx_head_held", tx_data, 8'h41);
    drain(10);

    // Overflow, clear, and push-while-full with a pop.
    for (int i = 0; i < 9; i++) push_byte(8'(8'h30 + i));
    access(MB + 32'h04, 0, 1'b0, 1'b1);
    check("status_ovf_full", dmem_rdata, 32'h5);
    access(MB + 32'h04, 32'h4, 1'b1, 1'b0);
    access(MB + 32'h04, 0, 1'b0, 1'b1);
    check("status_after_clear", dmem_rdata, 32'h1);
    access(MB, 32'h39, 1'b1, 1'b0);
    tx_ready = 1'b1;
    check("full_pop_head", tx_data, sb.pop_front());
    sb.push_back(8'h39);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    access(MB + 32'h04, 0, 1'b0, 1'b1);
    check("status_push_pop_full", dmem_rdata, 32'h1);
    idle();
    drain(20);

    // Shadow must hold the upper half sampled with the LO read, not the carried value.
    @(negedge clk);
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    dmem_addr = MB + 32'h08; dmem_wdata = 0; dmem_we = 1'b0; dmem_re = 1'b1;
    #1;
    check("cycle_lo_forced", dmem_rdata, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    release dut.cycle_cnt;
    access(MB + 32'h0C, 0, 1'b0, 1'b1);
    check("cycle_hi_no_carry", dmem_rdata, 32'h0);

    idle();
    check("halt_before_exit", halt, 0);
    access(MB + 32'h10, 32'h2A, 1'b1, 1'b0);
    access(MB + 32'h10, 32'h7, 1'b1, 1'b0);
    idle();
    check("halt_set", halt, 1);
    check("halt_code_first_wins", halt_code, 32'h2A);
    check("err_clean_before_misalign", err, 0);

    access(32'h43, 0, 1'b0, 1'b1);
    check("misaligned_rdata", dmem_rdata, 32'h1);
    idle();
    check("err_misaligned", err, 1);
    access(32'h8000_0000, 0, 1'b0, 1'b1);
    check("unmapped_rdata", dmem_rdata, 32'h0);
    idle();
    check("err_sticky", err, 1);

    // Reset with a byte still queued.
    push_byte(8'h55);
    idle();
    check("tx_valid_before_reset", tx_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    dmem_addr = 32'h40; dmem_we = 1'b0; dmem_re = 1'b1;
    #1;
    check("rdata_during_reset", dmem_rdata, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_addr = MB + 32'h08;
    #1;
    check("post_rst_tx_valid", tx_valid, 0);
    check("post_rst_tx_data", tx_data, 0);
    check("post_rst_halt", halt, 0);
    check("post_rst_halt_code", halt_code, 0);
    check("post_rst_err", err, 0);
    check("post_rst_cycle_lo", dmem_rdata, 0);
    sb.delete();
    access(MB + 32'h04, 0, 1'b0, 1'b1);
    check("post_rst_status", dmem_rdata, 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Data-side memory responder for the single-cycle RV32E core: the slave end of the core's word-wide Harvard data interface (address, write data, read data, write enable, read enable). Serves a word RAM plus a small MMIO window: byte TX FIFO, 64-bit cycle counter, halt/exit register, sticky error flag. Reads are combinational for same-cycle load completion; all writes and state updates occur on the clock edge.

## Interface
- RAM_WORDS, 1024: RAM size in 32-bit words (power of two); RAM occupies byte addresses 0 .. RAM_WORDS*4-1
- TX_DEPTH, 8: TX FIFO entries (power of two, ≥2)
- MMIO_BASE, 32'h1000_0000: base byte address of MMIO window (0x20 bytes)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset synchronous and active-low
- dmem_addr  in  32  byte address from core
- dmem_wdata  in  32  store data
- dmem_we  in  1  store strobe
- dmem_re  in  1  load strobe
- dmem_rdata  out  32  load data, combinational
- tx_valid  out  1  TX FIFO non-empty
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  consumer accepts head when tx_valid
- halt  out  1  sticky: program wrote exit register
- halt_code  out  32  value written to exit register
- err  out  1  sticky: misaligned or unmapped access

## Operation
- Word-only: no byte enables. Access counts when dmem_we|dmem_re. addr[1:0]≠0 → err set; access still performed at addr with [1:0] masked.
- RAM: index addr[log2(RAM_WORDS)+1:2]. Write at edge when we. Contents not reset.
- dmem_rdata = selected word when re, else 0. re&we same cycle: rdata returns pre-write value; write commits at edge.
- MMIO offsets:
  - +0x00 TXDATA: W pushes wdata[7:0]; R returns 0.
  - +0x04 STATUS: R {29'b0, overflow, empty, full}; W with wdata[2]=1 clears overflow.
  - +0x08 CYCLE_LO: R returns counter[31:0] and captures counter[63:32] into hi_shadow at edge.
  - +0x0C CYCLE_HI: R returns hi_shadow. Writes to +0x08/+0x0C ignored.
  - +0x10 EXIT: W sets halt=1, halt_code=wdata, only when halt=0 (first write wins).
  - +0x14..+0x1F: read 0, write ignored, no err.
- Any other address outside RAM and window → read 0, write ignored, err set.
- Cycle counter: 64-bit, 0 after reset, +1 every cycle, wraps at 2^64-1 → 0.
- TX FIFO: push accepted if count<TX_DEPTH, or count==TX_DEPTH with a pop in the same cycle. Rejected push → overflow=1, data dropped. Pop when tx_valid&tx_ready. tx_data = head when non-empty, else 0.
- halt does not block further accesses; the core/bench decides when to stop.

## Timing
- Reset (rst_n low at edge): FIFO empty, tx_valid 0, tx_data 0, overflow 0, counter 0, hi_shadow 0, halt 0, halt_code 0, err 0. dmem_rdata follows inputs combinationally even in reset (RAM/0). Reset mid-FIFO-drain discards all entries.
- Load latency 0 cycles (combinational). Store visible to loads from next cycle.
- Push into empty FIFO: tx_valid rises next cycle. Status read reflects pre-edge state.
- CYCLE_LO read in cycle N returns N (cycles since reset release); shadow holds N's upper half from N+1.
- Simultaneous STATUS overflow-clear and rejected push: overflow ends at 1 (set wins).

## Structure
- Package dmem_mmio_pkg: offset constants (TXDATA, STATUS, CYCLE_LO, CYCLE_HI, EXIT), status bit indices, window size.
- Sub-module dmem_mmio_tx_fifo: synchronous FIFO, parameter depth, push/pop/full/empty/count, push-while-full-with-pop allowed.
- Top: address decode, RAM array, counter, shadow, exit/err regs.

## Test plan
- Store 0xDEADBEEF to 0x40, load 0x40 next cycle → rdata 0xDEADBEEF; same-cycle re&we with 0x1 → rdata 0xDEADBEEF, next load 0x1.
- Push 'A','B','C' with tx_ready=0 → tx_valid=1, tx_data 0x41; raise tx_ready → bytes 0x41,0x42,0x43 on consecutive cycles, then tx_valid=0.
- Push 9 bytes with TX_DEPTH=8, tx_ready=0 → STATUS reads 0x5 (overflow|full); write 0x4 to STATUS → reads 0x1; full + push + pop same cycle → accepted, overflow stays 0.
- Read CYCLE_LO at cycle 10 → 10; force counter to 0x0000_0000_FFFF_FFFF, read LO then HI → 0xFFFF_FFFF then 0x0 (shadow, not post-carry 0x1).
- Write 0x2A then 0x7 to EXIT → halt=1, halt_code=0x2A.
- Load 0x43 → err=1 and rdata = word at 0x40; load 0x8000_0000 → rdata 0, err stays 1; assert rst_n low one cycle → all outputs at reset values.
